// File: rtl/seg7_scan_driver_if.sv
// Value/control bundle between a producer and the 6-digit 7-segment scan driver.
// The producer drives the value and strobes; the driver returns status and pins.
interface seg7_scan_driver_if;
  logic [23:0] data_in;
  logic        load;
  logic        lzb_en;
  logic        pending;
  logic        frame_tick;
  logic [6:0]  db;
  logic [5:0]  cs;

  modport master (
    output data_in, load, lzb_en,
    input  pending, frame_tick, db, cs
  );

  modport slave (
    input  data_in, load, lzb_en,
    output pending, frame_tick, db, cs
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 6-digit 7-segment driver with frame-synchronous value commit,
// per-slot blanking gap and optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit CS_ACT_LOW   = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int TW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(DIGIT_CYCLES - 1);
  localparam logic [TW-1:0] T_BLANK = TW'(BLANK_CYCLES);
  localparam logic [6:0] DB_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0] CS_OFF = CS_ACT_LOW ? 6'h3F : 6'h00;

  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic [23:0]   staging;
  logic [23:0]   display;
  logic          pending;
  logic          frame_tick;
  logic [6:0]    db;
  logic [5:0]    cs;

  logic          frame_end;
  logic [7:0]    lead_zero;
  logic          blank;
  logic [3:0]    nib;
  logic [6:0]    seg_hi;
  logic [5:0]    sel;
  logic [6:0]    db_nx;
  logic [5:0]    cs_nx;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign frame_end = (timer == T_LAST) && (idx == 3'd5);
  assign nib       = display[{idx, 2'b00} +: 4];
  assign seg_hi    = seg_code(nib);
  assign sel       = 6'b000001 << idx;

  // Digit k is a leading zero when every nibble from k upward is zero.
  always_comb begin
    lead_zero = '0;
    for (int k = 1; k < 6; k++) begin
      lead_zero[k] = (display >> (4 * k)) == 24'd0;
    end
  end

  assign blank = bus.lzb_en && lead_zero[idx];

  always_comb begin
    db_nx = DB_OFF;
    cs_nx = CS_OFF;
    if (timer >= T_BLANK && !blank) begin
      db_nx = SEG_ACT_LOW ? ~seg_hi : seg_hi;
      cs_nx = CS_ACT_LOW ? ~sel : sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      idx        <= '0;
      staging    <= '0;
      display    <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      db         <= DB_OFF;
      cs         <= CS_OFF;
    end else begin
      db         <= db_nx;
      cs         <= cs_nx;
      frame_tick <= frame_end;
      if (timer == T_LAST) begin
        timer <= '0;
        idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        timer <= timer + 1'b1;
      end
      // A load landing on the frame edge bypasses staging straight to display.
      if (frame_end) begin
        if (bus.load) begin
          display <= bus.data_in;
          staging <= bus.data_in;
          pending <= 1'b0;
        end else if (pending) begin
          display <= staging;
          pending <= 1'b0;
        end
      end else if (bus.load) begin
        staging <= bus.data_in;
        pending <= 1'b1;
      end
    end
  end

  assign bus.pending    = pending;
  assign bus.frame_tick = frame_tick;
  assign bus.db         = db;
  assign bus.cs         = cs;

endmodule
